// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped I/O hub for the OTTER IOBUS.
// N_OUT registered output ports, N_IN synchronised input ports on a
// base+stride map, plus an edge-triggered interrupt controller
// (PENDING / MASK / IRQ_ID) driving a single registered INTR line.
module mmio_io_hub #(
  parameter int          N_OUT       = 4,
  parameter int          N_IN        = 4,
  parameter int          N_IRQ       = 2,
  parameter int          DATA_W      = 16,
  parameter logic [31:0] OUT_BASE    = 32'h1108_0000,
  parameter logic [31:0] IN_BASE     = 32'h1100_0000,
  parameter logic [31:0] CTRL_BASE   = 32'h1120_0000,
  parameter logic [31:0] STRIDE      = 32'h0004_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [31:0]             IOBUS_ADDR,
  input  logic [31:0]             IOBUS_OUT,
  input  logic                    IOBUS_WR,
  output logic [31:0]             IOBUS_IN,
  output logic [N_OUT*DATA_W-1:0] OUT_DATA,
  output logic [N_OUT-1:0]        OUT_STB,
  input  logic [N_IN*DATA_W-1:0]  IN_DATA,
  input  logic [N_IRQ-1:0]        IRQ_SRC,
  output logic                    INTR
);

  localparam logic [31:0] PEND_ADDR = CTRL_BASE;
  localparam logic [31:0] MASK_ADDR = CTRL_BASE + STRIDE;
  localparam logic [31:0] ID_ADDR   = CTRL_BASE + (STRIDE << 1);

  logic [N_IN*DATA_W-1:0]  in_sync_q  [SYNC_STAGES];
  logic [N_IRQ-1:0]        irq_sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0]        irq_prev_q;
  logic [N_OUT*DATA_W-1:0] out_data_q;
  logic [N_OUT-1:0]        out_stb_q;
  logic [N_OUT-1:0]        out_hit;
  logic [N_IRQ-1:0]        pend_q, pend_d;
  logic [N_IRQ-1:0]        mask_q, mask_d;
  logic [N_IRQ-1:0]        irq_rise;
  logic [N_IRQ-1:0]        pend_w1c;
  logic                    intr_q;
  logic                    ctrl_hit;
  logic [N_IN*DATA_W-1:0]  in_sync_last;
  logic [31:0]             irq_id;
  logic [31:0]             rd_data;
  logic                    unused_wdata;

  // Upper write-data bits are not stored when ports are narrower than 32.
  assign unused_wdata = ^IOBUS_OUT;

  // Control addresses shadow any output/input decode that lands on them.
  assign ctrl_hit = (IOBUS_ADDR == PEND_ADDR) || (IOBUS_ADDR == MASK_ADDR) ||
                    (IOBUS_ADDR == ID_ADDR);

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out_dec
      assign out_hit[gi] = IOBUS_WR && !ctrl_hit &&
                           (IOBUS_ADDR == OUT_BASE + 32'(gi) * STRIDE);
    end
  endgenerate

  // Synchroniser chains for peripheral data and interrupt levels.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        in_sync_q[s]  <= '0;
        irq_sync_q[s] <= '0;
      end
    end else begin
      in_sync_q[0]  <= IN_DATA;
      irq_sync_q[0] <= IRQ_SRC;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        in_sync_q[s]  <= in_sync_q[s-1];
        irq_sync_q[s] <= irq_sync_q[s-1];
      end
    end
  end

  assign in_sync_last = in_sync_q[SYNC_STAGES-1];

  // Output registers and their one-cycle write strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_data_q <= '0;
      out_stb_q  <= '0;
    end else begin
      out_stb_q <= out_hit;
      for (int i = 0; i < N_OUT; i++) begin
        if (out_hit[i]) out_data_q[i*DATA_W +: DATA_W] <= IOBUS_OUT[DATA_W-1:0];
      end
    end
  end

  // Pending/mask next state: a fresh rising edge beats a simultaneous W1C.
  always_comb begin
    irq_rise = irq_sync_q[SYNC_STAGES-1] & ~irq_prev_q;
    pend_w1c = (IOBUS_WR && IOBUS_ADDR == PEND_ADDR) ? IOBUS_OUT[N_IRQ-1:0] : '0;
    pend_d   = (pend_q & ~pend_w1c) | irq_rise;
    mask_d   = (IOBUS_WR && IOBUS_ADDR == MASK_ADDR) ? IOBUS_OUT[N_IRQ-1:0] : mask_q;
  end

  // Interrupt controller state and the registered INTR line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      intr_q     <= 1'b0;
    end else begin
      irq_prev_q <= irq_sync_q[SYNC_STAGES-1];
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      intr_q     <= |(pend_q & mask_q);
    end
  end

  // IRQ_ID: one-based index of the lowest enabled pending source.
  always_comb begin
    irq_id = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (pend_q[k] && mask_q[k]) irq_id = 32'(k + 1);
    end
  end

  // Zero-latency read mux; unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    if (IOBUS_ADDR == PEND_ADDR) begin
      rd_data[N_IRQ-1:0] = pend_q;
    end else if (IOBUS_ADDR == MASK_ADDR) begin
      rd_data[N_IRQ-1:0] = mask_q;
    end else if (IOBUS_ADDR == ID_ADDR) begin
      rd_data = irq_id;
    end else begin
      for (int j = 0; j < N_IN; j++) begin
        if (IOBUS_ADDR == IN_BASE + 32'(j) * STRIDE)
          rd_data[DATA_W-1:0] = in_sync_last[j*DATA_W +: DATA_W];
      end
    end
  end

  assign IOBUS_IN = rd_data;
  assign OUT_DATA = out_data_q;
  assign OUT_STB  = out_stb_q;
  assign INTR     = intr_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Bench for mmio_io_hub: directed scenarios plus randomized bus traffic,
// checked every cycle against a behavioural model of the register map.
module tb_mmio_io_hub;
  localparam int          N_OUT = 4, N_IN = 4, N_IRQ = 2, DW = 16, SS = 2;
  localparam logic [31:0] OUT_BASE  = 32'h1108_0000;
  localparam logic [31:0] IN_BASE   = 32'h1100_0000;
  localparam logic [31:0] CTRL_BASE = 32'h1120_0000;
  localparam logic [31:0] STRIDE    = 32'h0004_0000;
  localparam logic [31:0] PEND_A = CTRL_BASE;
  localparam logic [31:0] MASK_A = CTRL_BASE + STRIDE;
  localparam logic [31:0] ID_A   = CTRL_BASE + 2 * STRIDE;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic        wr;
  logic [31:0] rdata;
  logic [63:0] out_data;
  logic [3:0]  out_stb;
  logic [63:0] in_data;
  logic [1:0]  irq_src;
  logic        intr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmio_io_hub #(
    .N_OUT(N_OUT), .N_IN(N_IN), .N_IRQ(N_IRQ), .DATA_W(DW),
    .OUT_BASE(OUT_BASE), .IN_BASE(IN_BASE), .CTRL_BASE(CTRL_BASE),
    .STRIDE(STRIDE), .SYNC_STAGES(SS)
  ) dut (
    .CLK(clk), .RST(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata),
    .IOBUS_WR(wr), .IOBUS_IN(rdata), .OUT_DATA(out_data), .OUT_STB(out_stb),
    .IN_DATA(in_data), .IRQ_SRC(irq_src), .INTR(intr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_out;
  logic [3:0]  m_stb;
  logic [1:0]  m_pend, m_mask, m_prev, m_rise, m_w1c;
  logic        m_intr;
  logic [63:0] h_in  [SS];   // h_in[SS-1] = value the bus can currently see
  logic [1:0]  h_irq [SS];

  function automatic logic is_ctrl(input logic [31:0] a);
    return (a == PEND_A) || (a == MASK_A) || (a == ID_A);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a == PEND_A) r = {30'h0, m_pend};
    else if (a == MASK_A) r = {30'h0, m_mask};
    else if (a == ID_A) begin
      if (m_pend[0] && m_mask[0]) r = 32'd1;
      else if (m_pend[1] && m_mask[1]) r = 32'd2;
    end else begin
      for (int j = 0; j < N_IN; j++)
        if (a == IN_BASE + j * STRIDE) r = {16'h0, h_in[SS-1][j*DW +: DW]};
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = '0; m_stb = '0; m_pend = '0; m_mask = '0; m_prev = '0; m_intr = 1'b0;
      for (int s = 0; s < SS; s++) begin h_in[s] = '0; h_irq[s] = '0; end
    end else begin
      m_rise = h_irq[SS-1] & ~m_prev;
      m_prev = h_irq[SS-1];
      m_intr = |(m_pend & m_mask);
      m_w1c  = (wr && addr == PEND_A) ? wdata[1:0] : 2'b00;
      m_stb  = '0;
      if (wr && addr == MASK_A) m_mask = wdata[1:0];
      for (int i = 0; i < N_OUT; i++)
        if (wr && !is_ctrl(addr) && addr == OUT_BASE + i * STRIDE) begin
          m_out[i*DW +: DW] = wdata[DW-1:0];
          m_stb[i] = 1'b1;
        end
      m_pend = (m_pend & ~m_w1c) | m_rise;
      for (int s = SS - 1; s > 0; s--) begin h_in[s] = h_in[s-1]; h_irq[s] = h_irq[s-1]; end
      h_in[0]  = in_data;
      h_irq[0] = irq_src;
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    check("out_data", out_data, m_out);
    check("out_stb", {60'h0, out_stb}, {60'h0, m_stb});
    check("intr", {63'h0, intr}, {63'h0, m_intr});
    check("iobus_in", {32'h0, rdata}, {32'h0, m_read(addr)});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wr = 1'b0; in_data = '0; irq_src = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out", out_data, 64'h0);
    check("rst_intr", {63'h0, intr}, 64'h0);

    // Output write to port 1
    bus_write(OUT_BASE + STRIDE, 32'hABCD_1234);
    check("wr_port1", {48'h0, out_data[31:16]}, 64'h1234);
    check("wr_others", {out_data[63:32], 16'h0, out_data[15:0]}, 64'h0);
    check("wr_stb", {60'h0, out_stb}, 64'h2);
    tick();
    check("stb_clear", {60'h0, out_stb}, 64'h0);
    check("port1_hold", {48'h0, out_data[31:16]}, 64'h1234);

    // Input synchroniser latency
    in_data[2*DW +: DW] = 16'h00F0;
    addr = IN_BASE + 2 * STRIDE;
    #1 check("in_lat0", {32'h0, rdata}, 64'h0);
    tick();
    check("in_lat1", {32'h0, rdata}, 64'h0);
    tick();
    check("in_lat2", {32'h0, rdata}, 64'h0000_00F0);
    addr = 32'h1130_0000;
    #1 check("unmapped", {32'h0, rdata}, 64'h0);

    // Masked-in interrupt path and W1C
    bus_write(MASK_A, 32'h3);
    irq_src = 2'b10;
    addr = PEND_A;
    tick(); tick();
    check("pend_2edges", {32'h0, rdata}, 64'h0);
    tick();
    check("pend_3edges", {32'h0, rdata}, 64'h2);
    check("intr_3edges", {63'h0, intr}, 64'h0);
    tick();
    check("intr_4edges", {63'h0, intr}, 64'h1);
    addr = ID_A;
    #1 check("irq_id", {32'h0, rdata}, 64'h2);
    bus_write(PEND_A, 32'h2);
    tick();
    check("intr_w1c", {63'h0, intr}, 64'h0);
    irq_src = 2'b00;

    // Masked-out pulse, then re-enable
    bus_write(MASK_A, 32'h0);
    irq_src = 2'b01;
    tick();
    irq_src = 2'b00;
    tick(); tick(); tick(); tick();
    addr = PEND_A;
    #1 check("pend_masked", {32'h0, rdata}, 64'h1);
    check("intr_masked", {63'h0, intr}, 64'h0);
    bus_write(MASK_A, 32'h1);
    tick();
    check("intr_unmask", {63'h0, intr}, 64'h1);

    // W1C colliding with a fresh edge: set wins
    irq_src = 2'b01;
    tick(); tick();
    bus_write(PEND_A, 32'h1);
    addr = PEND_A;
    #1 check("set_wins", {32'h0, rdata}, 64'h1);
    tick();
    check("intr_kept", {63'h0, intr}, 64'h1);

    // Asynchronous reset mid-operation; a write during reset is discarded
    #1 rst = 1'b1;
    #1;
    check("arst_out", out_data, 64'h0);
    check("arst_stb", {60'h0, out_stb}, 64'h0);
    check("arst_intr", {63'h0, intr}, 64'h0);
    addr = CTRL_BASE;
    #1 check("arst_pend", {32'h0, rdata}, 64'h0);
    addr = OUT_BASE; wdata = 32'h5555; wr = 1'b1;
    tick(); tick();
    check("arst_wr_drop", out_data, 64'h0);
    wr = 1'b0;
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 11);
      if (sel < 4)       addr = OUT_BASE + sel * STRIDE;
      else if (sel < 8)  addr = IN_BASE + (sel - 4) * STRIDE;
      else if (sel == 8) addr = PEND_A;
      else if (sel == 9) addr = MASK_A;
      else if (sel == 10) addr = ID_A;
      else               addr = $urandom();
      wdata = $urandom();
      wr = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) in_data = {$urandom(), $urandom()};
      if ($urandom_range(0, 5) == 0) irq_src = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end
    wr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
